// File: rtl/final_cos.sv
`default_nettype none
// ============================================================================
// Module   : final_cos
// Purpose  : Sequential cos(x) by truncated Taylor series in Q8.8 fixed point.
//            cos(x) ~= 1 - x^2/2! + x^4/4! - x^6/6!, using at most 4 terms and
//            one term per clock. This file also holds final_cos_2, an
//            alternate implementation that is pin- and cycle-compatible and
//            produces bit-identical results.
// Ports    : x       in  16  angle, signed Q8.8 radians
//            y       in   8  requested term count N (clamped to 1..4)
//            start   in   1  level request; computation begins on release
//            clk     in   1  rising-edge clock
//            rst     in   1  asynchronous active-low reset
//            ready   out  1  idle and result valid
//            outCosx out 16  cos(x), signed Q8.8, held until next result
// Revision : 1.0 - initial release
// ============================================================================
module final_cos (
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic        start,
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  output logic [15:0] outCosx
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    LOAD     = 3'd2,
    SQUARE   = 3'd3,
    ITER     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ready;
  logic [15:0]        r_out;
  logic signed [15:0] r_x;
  logic signed [15:0] r_x2;
  logic signed [15:0] r_acc;
  logic signed [31:0] r_power;
  logic [2:0]         r_neff;
  logic [2:0]         r_k;

  logic [2:0]         w_neff;
  logic signed [8:0]  w_coef;
  logic signed [31:0] w_x2_full;
  logic signed [40:0] w_term_full;
  logic signed [47:0] w_pow_full;
  logic signed [15:0] w_x2;
  logic signed [15:0] w_term;
  logic signed [31:0] w_pow_nxt;
  logic               w_last;

  // Requested term count clamped to 1..4.
  always_comb begin
    w_neff = y[2:0];
    if (y == 8'd0) begin
      w_neff = 3'd1;
    end else if (y > 8'd4) begin
      w_neff = 3'd4;
    end
  end

  // Q8.8 coefficients 1/(2k)!; 1/720 rounds to zero.
  always_comb begin
    w_coef = 9'sd0;
    case (r_k)
      3'd1:    w_coef = 9'sd128;
      3'd2:    w_coef = 9'sd11;
      default: w_coef = 9'sd0;
    endcase
  end

  // Full-width products; the Q8.8 realignment keeps the bits above the
  // 8-bit fraction and wraps into the destination width.
  assign w_x2_full   = r_x * r_x;
  assign w_term_full = r_power * w_coef;
  assign w_pow_full  = r_power * r_x2;
  assign w_x2        = 16'(w_x2_full >>> 8);
  assign w_term      = 16'(w_term_full >>> 8);
  assign w_pow_nxt   = 32'(w_pow_full >>> 8);
  assign w_last      = (r_k == (r_neff - 3'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start)  w_state_nxt = WAIT_REL;
      WAIT_REL: if (!start) w_state_nxt = LOAD;
      LOAD:     w_state_nxt = SQUARE;
      SQUARE:   w_state_nxt = (r_neff == 3'd1) ? DONE : ITER;
      ITER:     if (w_last) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_out   <= 16'h0000;
      r_x     <= 16'sd0;
      r_x2    <= 16'sd0;
      r_acc   <= 16'sd0;
      r_power <= 32'sd0;
      r_neff  <= 3'd0;
      r_k     <= 3'd0;
    end else begin
      // Ready tracks the state we are about to enter, so it is high
      // exactly while idle.
      r_ready <= (w_state_nxt == IDLE);
      case (r_state)
        LOAD: begin
          r_x    <= $signed(x);
          r_neff <= w_neff;
          r_acc  <= 16'sd256;
          r_k    <= 3'd1;
        end
        SQUARE: begin
          r_x2    <= w_x2;
          r_power <= {{16{w_x2[15]}}, w_x2};
        end
        ITER: begin
          // Odd terms of the cosine series are negative.
          r_acc   <= r_k[0] ? (r_acc - w_term) : (r_acc + w_term);
          r_power <= w_pow_nxt;
          r_k     <= r_k + 3'd1;
        end
        DONE: begin
          r_out <= r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign outCosx = r_out;

endmodule

// ============================================================================
// Module   : final_cos_2
// Purpose  : Alternate cos(x) implementation, interchangeable with final_cos.
//            The square is formed while loading, terms are counted down, and
//            the constant multiplies are done with shifts and adds.
// Ports    : identical to final_cos
// Revision : 1.0 - initial release
// ============================================================================
module final_cos_2 (
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic        start,
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  output logic [15:0] outCosx
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    LOAD     = 3'd2,
    SQUARE   = 3'd3,
    ITER     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ready;
  logic [15:0]        r_out;
  logic signed [15:0] r_x2;
  logic signed [15:0] r_acc;
  logic signed [31:0] r_power;
  logic [1:0]         r_left;   // terms still to accumulate
  logic [1:0]         r_csel;   // one-hot coefficient select: [0]=1/2, [1]=1/24
  logic               r_sub;    // current term is subtracted

  logic signed [31:0] w_sq_full;
  logic signed [35:0] w_p36;
  logic signed [35:0] w_p11;
  logic signed [47:0] w_pow_full;
  logic signed [15:0] w_term;
  logic [1:0]         w_left_init;

  assign w_sq_full = $signed(x) * $signed(x);

  // Clamped term count minus one: y=0 or 1 -> 0, y>4 -> 3.
  always_comb begin
    w_left_init = 2'd0;
    if (y > 8'd4) begin
      w_left_init = 2'd3;
    end else if (y >= 8'd2) begin
      w_left_init = 2'(y - 8'd1);
    end
  end

  // power*11 as 8p + 2p + p; power*128 >>> 8 reduces to power >>> 1.
  assign w_p36 = {{4{r_power[31]}}, r_power};
  assign w_p11 = (w_p36 <<< 3) + (w_p36 <<< 1) + w_p36;

  always_comb begin
    w_term = 16'sd0;
    if (r_csel[0]) begin
      w_term = 16'(r_power >>> 1);
    end else if (r_csel[1]) begin
      w_term = 16'(w_p11 >>> 8);
    end
  end

  assign w_pow_full = r_power * r_x2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start)  w_state_nxt = WAIT_REL;
      WAIT_REL: if (!start) w_state_nxt = LOAD;
      LOAD:     w_state_nxt = SQUARE;
      SQUARE:   w_state_nxt = (r_left == 2'd0) ? DONE : ITER;
      ITER:     if (r_left == 2'd1) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_out   <= 16'h0000;
      r_x2    <= 16'sd0;
      r_acc   <= 16'sd0;
      r_power <= 32'sd0;
      r_left  <= 2'd0;
      r_csel  <= 2'd0;
      r_sub   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      case (r_state)
        LOAD: begin
          r_x2   <= 16'(w_sq_full >>> 8);
          r_left <= w_left_init;
          r_acc  <= 16'sd256;
          r_csel <= 2'b01;
          r_sub  <= 1'b1;
        end
        SQUARE: begin
          r_power <= {{16{r_x2[15]}}, r_x2};
        end
        ITER: begin
          r_acc   <= r_sub ? (r_acc - w_term) : (r_acc + w_term);
          r_power <= 32'(w_pow_full >>> 8);
          r_left  <= r_left - 2'd1;
          r_csel  <= {r_csel[0], 1'b0};
          r_sub   <= ~r_sub;
        end
        DONE: begin
          r_out <= r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign outCosx = r_out;

endmodule
`default_nettype wire

// File: tb/tb_final_cos.sv
`default_nettype none
// ============================================================================
// Module   : tb_final_cos
// Purpose  : Self-checking bench for final_cos, with final_cos_2 run in
//            lock-step on the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_final_cos;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [7:0]  y;
  logic        start;
  logic        ready1;
  logic        ready2;
  logic [15:0] out1;
  logic [15:0] out2;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_prev;

  typedef struct {
    logic [15:0] vx;
    logic [7:0]  vy;
    logic [15:0] vexp;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  final_cos u_dut (
    .x       (x),
    .y       (y),
    .start   (start),
    .clk     (clk),
    .rst     (rst),
    .ready   (ready1),
    .outCosx (out1)
  );

  final_cos_2 u_alt (
    .x       (x),
    .y       (y),
    .start   (start),
    .clk     (clk),
    .rst     (rst),
    .ready   (ready2),
    .outCosx (out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: start held for 'hold' cycles, operands presented on
  // release, operands scrambled and start pulsed while busy.
  task automatic run(input logic [15:0] vx, input logic [7:0] vy,
                     input logic [15:0] vexp, input int hold);
    int   cyc;
    int   neff;
    logic busy_ok;
    logic eq_ok;
    neff    = (vy == 8'd0) ? 1 : ((vy > 8'd4) ? 4 : int'(vy));
    busy_ok = 1'b1;
    eq_ok   = 1'b1;
    start   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready1 !== 1'b0 || out1 !== exp_prev) busy_ok = 1'b0;
    end
    start = 1'b0;
    x     = vx;
    y     = vy;
    cyc   = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready1 !== ready2 || out1 !== out2) eq_ok = 1'b0;
      if (ready1 === 1'b1) break;
      if (out1 !== exp_prev) busy_ok = 1'b0;
      if (cyc == 2) begin
        x     = ~vx;
        y     = ~vy;
        start = 1'b1;
      end
      if (cyc == 3) start = 1'b0;
    end
    // cyc counts from the LOAD cycle at cyc=1.
    chk($sformatf("latency x=%h y=%h", vx, vy), 32'(cyc), 32'(neff + 3));
    chk($sformatf("cos x=%h y=%h", vx, vy), {16'h0, out1}, {16'h0, vexp});
    chk($sformatf("alt cos x=%h y=%h", vx, vy), {16'h0, out2}, {16'h0, vexp});
    chk($sformatf("busy hold x=%h y=%h", vx, vy), {31'h0, busy_ok}, 32'h1);
    chk($sformatf("alt equiv x=%h y=%h", vx, vy), {31'h0, eq_ok}, 32'h1);
    exp_prev = vexp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_prev = 16'h0000;

    vecs[0]  = '{16'h00F5, 8'd5,   16'h0094, 1};
    vecs[1]  = '{16'h024C, 8'h73,  16'hFF8E, 1};
    vecs[2]  = '{16'h00F5, 8'd0,   16'h0100, 1};
    vecs[3]  = '{16'h00F5, 8'd1,   16'h0100, 1};
    vecs[4]  = '{16'h00F5, 8'd2,   16'h008B, 10};
    vecs[5]  = '{16'hFF0B, 8'd4,   16'h0094, 1};
    vecs[6]  = '{16'h0080, 8'd3,   16'h00E0, 2};
    vecs[7]  = '{16'h7FFF, 8'd4,   16'h018B, 1};
    vecs[8]  = '{16'h8000, 8'hFF,  16'h0100, 1};
    vecs[9]  = '{16'h0B50, 8'd4,   16'h80B7, 1};
    vecs[10] = '{16'h0C00, 8'd3,   16'h5400, 1};
    vecs[11] = '{16'h0000, 8'd3,   16'h0100, 1};

    rst   = 1'b0;
    start = 1'b0;
    x     = 16'h0000;
    y     = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset ready", {31'h0, ready1}, 32'h1);
    chk("reset out", {16'h0, out1}, 32'h0);
    chk("reset alt ready", {31'h0, ready2}, 32'h1);
    chk("reset alt out", {16'h0, out2}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Runs are back to back: each starts on the cycle ready rose.
    for (int i = 0; i < 12; i++) begin
      run(vecs[i].vx, vecs[i].vy, vecs[i].vexp, vecs[i].hold);
    end

    // Abort in ITER with an asynchronous reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = 16'h00F5;
    y     = 8'd4;
    repeat (3) @(negedge clk);   // LOAD, SQUARE, ITER
    rst = 1'b0;
    #1;
    chk("abort ready", {31'h0, ready1}, 32'h1);
    chk("abort out", {16'h0, out1}, 32'h0);
    chk("abort alt ready", {31'h0, ready2}, 32'h1);
    chk("abort alt out", {16'h0, out2}, 32'h0);
    exp_prev = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(16'h0000, 8'd3, 16'h0100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/final_cos.md
FINAL_COS -- requirements
Module: final_cos

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 x  input  16  angle in radians, signed two's-complement Q8.8.
REQ-005 y  input  8  unsigned requested Taylor term count N.
REQ-006 start  input  1  level request; a computation begins on its release (high then low).
REQ-007 ready  output  1  high when idle and the result is valid; low while busy.
REQ-008 outCosx  output  16  cos(x) result, signed Q8.8, held until the next result.
REQ-009 Positional port order SHALL be x, y, start, clk, rst, ready, outCosx.

Function
REQ-010 The FSM states SHALL be IDLE, WAIT_REL, LOAD, SQUARE, ITER and DONE.
REQ-011 IDLE: ready=1; start=1 moves to WAIT_REL.
REQ-012 WAIT_REL: ready=0; stay while start=1; start=0 moves to LOAD.
REQ-013 LOAD: capture x and y; N_eff = 1 if y=0, 4 if y>4, else y.
REQ-014 LOAD: clear the accumulator to 256 (1.0) and set the term index k=1.
REQ-015 SQUARE: x2 = (x*x)>>>8 using a signed 32-bit product, truncated to 16 bits; the power register is set to x2.
REQ-016 ITER: one cycle per term k = 1 .. N_eff-1; skip directly to DONE if N_eff=1.
REQ-017 Term: term = (power*c[k])>>>8, with c[1]=128, c[2]=11 and c[3]=0 (Q8.8 values of 1/(2k)!, rounded to nearest).
REQ-018 Accumulate: odd k subtracts term, even k adds term.
REQ-019 After each term, power = (power*x2)>>>8, kept in a 32-bit signed register with wrap.
REQ-020 The accumulator SHALL be 16-bit signed and wrap on overflow; there is no saturation.
REQ-021 DONE: outCosx <= accumulator, ready <= 1, next state IDLE.
REQ-022 Latency from the LOAD cycle to ready=1 SHALL be N_eff+2 clock cycles.
REQ-023 outCosx SHALL change only in DONE.
REQ-024 start is ignored in LOAD, SQUARE, ITER and DONE.
REQ-025 x and y changes after LOAD SHALL NOT affect the current computation.
REQ-026 start held high indefinitely keeps the block in WAIT_REL with ready=0.
REQ-027 final_cos_2 SHALL be a pin- and cycle-compatible alternate implementation producing bit-identical outCosx and ready.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, ready=1, outCosx=0x0000, and clear all internal registers.
REQ-029 Reset asserted mid-computation SHALL abort it; outCosx returns to 0x0000 and no partial result is ever output.
REQ-030 After rst releases, the first start pulse SHALL be served normally.

Verification
REQ-031 Pulse start; on release set x=0x00F5, y=5 -> ready=1 after 6 cycles from LOAD, outCosx=0x0094.
REQ-032 Pulse start; on release set x=0x024C, y=0x73 -> N_eff=4, outCosx=0xFF8E.
REQ-033 Set x=0x00F5 with y=0, y=1, y=2 on separate runs -> 0x0100, 0x0100, 0x008B respectively.
REQ-034 Hold start high for 10 cycles -> ready stays 0 and outCosx unchanged; after release the run completes normally.
REQ-035 Assert rst during ITER -> immediate ready=1, outCosx=0x0000; a following run with x=0x0000, y=3 -> 0x0100.
REQ-036 Run a back-to-back second start immediately after ready rises -> the correct new result, and the previous value holds until DONE.
